// File: rtl/horizontal_timing_pkg.sv
// Shared VGA horizontal line geometry and phase encoding, imported by both the
// horizontal and vertical timing stages so they agree on line length.
package horizontal_timing_pkg;

    localparam int unsigned H_ACTIVE_PX = 640;
    localparam int unsigned H_FP_PX     = 16;
    localparam int unsigned H_SYNC_PX   = 96;
    localparam int unsigned H_BP_PX     = 48;
    localparam int unsigned H_TOTAL_PX  = H_ACTIVE_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;

    localparam int unsigned H_CNT_W = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/horizontal_timing.sv
// Horizontal pixel counter and phase machine for VGA timing; every output is
// registered and describes the pixel currently held in h_count.
module horizontal_timing
    import horizontal_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_PX,
    parameter int unsigned H_FP     = H_FP_PX,
    parameter int unsigned H_SYNC   = H_SYNC_PX,
    parameter int unsigned H_BP     = H_BP_PX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [H_CNT_W-1:0] h_count,
    output logic               enable_v_counter,
    output logic               hsync,
    output logic               h_active,
    output logic               line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [H_CNT_W-1:0] LAST_ACTIVE = H_CNT_W'(H_ACTIVE - 1);
    localparam logic [H_CNT_W-1:0] LAST_FRONT  = H_CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [H_CNT_W-1:0] LAST_SYNC   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [H_CNT_W-1:0] LAST_PX     = H_CNT_W'(H_TOTAL - 1);

    logic [H_CNT_W-1:0] count_q, count_d;
    phase_t             phase_q, phase_d;
    logic               hsync_q, hsync_d;
    logic               h_active_q, h_active_d;
    logic               line_start_q, line_start_d;
    logic               pulse_q, pulse_d;

    always_comb begin
        count_d      = count_q;
        phase_d      = phase_q;
        hsync_d      = hsync_q;
        h_active_d   = h_active_q;
        line_start_d = line_start_q;
        pulse_d      = 1'b0;

        if (en) begin
            if (count_q > LAST_PX) begin
                count_d = '0;
                phase_d = PH_ACTIVE;
            end else begin
                count_d = (count_q == LAST_PX) ? '0 : count_q + H_CNT_W'(1);
                case (phase_q)
                    PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
                    PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
                    PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
                    PH_BACK:   if (count_q == LAST_PX)     phase_d = PH_ACTIVE;
                    default: begin
                        count_d = '0;
                        phase_d = PH_ACTIVE;
                    end
                endcase
                // The line wrap always restarts ACTIVE, so a phase that drifted
                // out of step with the count is realigned once per line.
                if (count_q == LAST_PX) phase_d = PH_ACTIVE;
            end

            pulse_d      = (count_d == LAST_PX);
            hsync_d      = (phase_d != PH_SYNC);
            h_active_d   = (phase_d == PH_ACTIVE);
            line_start_d = (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            phase_q      <= PH_ACTIVE;
            hsync_q      <= 1'b1;
            h_active_q   <= 1'b1;
            line_start_q <= 1'b1;
            pulse_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            phase_q      <= phase_d;
            hsync_q      <= hsync_d;
            h_active_q   <= h_active_d;
            line_start_q <= line_start_d;
            pulse_q      <= pulse_d;
        end
    end

    assign h_count          = count_q;
    assign enable_v_counter = pulse_q;
    assign hsync            = hsync_q;
    assign h_active         = h_active_q;
    assign line_start       = line_start_q;

endmodule

// File: tb/tb_horizontal_timing.sv
// Self-checking bench for horizontal_timing: vector table, directed line
// sequences and randomized enable/reset against a per-pixel arithmetic model.
module tb_horizontal_timing;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [9:0] h_count;
    logic       enable_v_counter;
    logic       hsync;
    logic       h_active;
    logic       line_start;

    horizontal_timing dut (
        .clk              (clk),
        .reset            (reset),
        .en               (en),
        .h_count          (h_count),
        .enable_v_counter (enable_v_counter),
        .hsync            (hsync),
        .h_active         (h_active),
        .line_start       (line_start)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pixel position in the line plus whether this pixel was just entered.
    int m_count = 0;
    bit m_pulse = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic e);
        reset = r;
        en    = e;
        @(posedge clk);
        if (r) begin
            m_count = 0;
            m_pulse = 1'b0;
        end else if (e) begin
            m_count = (m_count + 1) % 800;
            m_pulse = (m_count == 799);
        end else begin
            m_pulse = 1'b0;
        end
        #1;
        chk("h_count", int'(h_count), m_count);
        chk("enable_v_counter", int'(enable_v_counter), int'(m_pulse));
        chk("hsync", int'(hsync), (m_count >= 656 && m_count <= 751) ? 0 : 1);
        chk("h_active", int'(h_active), (m_count < 640) ? 1 : 0);
        chk("line_start", int'(line_start), (m_count == 0) ? 1 : 0);
        $display("tick r=%0b en=%0b h_count=%0d vpulse=%0b hsync=%0b act=%0b ls=%0b",
                 r, e, h_count, enable_v_counter, hsync, h_active, line_start);
    endtask

    typedef struct {
        logic r;
        logic e;
        int   cnt;
        logic hs;
        logic act;
        logic ls;
        logic vp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses, first_p, second_p, hs_low, act_hi;
        int fall, rise, st1, st2;
        logic prev_hs, en_v;

        vecs[0] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0};

        #5;
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].r, vecs[i].e);
            chk("vec_count", int'(h_count), vecs[i].cnt);
            chk("vec_hsync", int'(hsync), int'(vecs[i].hs));
            chk("vec_active", int'(h_active), int'(vecs[i].act));
            chk("vec_line_start", int'(line_start), int'(vecs[i].ls));
            chk("vec_vpulse", int'(enable_v_counter), int'(vecs[i].vp));
        end

        // Free run: two reset cycles then 1600 enabled cycles.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        pulses = 0; first_p = -1; second_p = -1; hs_low = 0; act_hi = 0;
        for (int k = 1; k <= 1600; k++) begin
            tick(1'b0, 1'b1);
            if (enable_v_counter) begin
                pulses++;
                if (first_p < 0) first_p = k; else if (second_p < 0) second_p = k;
            end
            if (k <= 800) begin
                if (!hsync) hs_low++;
                if (h_active) act_hi++;
            end
            if (k == 800) chk("wrap_to_zero", int'(h_count), 0);
        end
        chk("free_pulses", pulses, 2);
        chk("free_first_pulse", first_p, 799);
        chk("free_second_pulse", second_p, 1599);
        chk("line_hsync_low", hs_low, 96);
        chk("line_active_high", act_hi, 640);

        // Reset mid-SYNC at pixel 700, with en high to show reset priority.
        tick(1'b1, 1'b0);
        for (int k = 0; k < 700; k++) tick(1'b0, 1'b1);
        chk("pre_reset_count", int'(h_count), 700);
        chk("pre_reset_hsync", int'(hsync), 0);
        tick(1'b1, 1'b1);
        chk("midreset_count", int'(h_count), 0);
        chk("midreset_hsync", int'(hsync), 1);
        chk("midreset_active", int'(h_active), 1);
        chk("midreset_ls", int'(line_start), 1);
        pulses = 0; first_p = -1;
        for (int k = 1; k <= 799; k++) begin
            tick(1'b0, 1'b1);
            if (enable_v_counter) begin
                pulses++;
                if (first_p < 0) first_p = k;
            end
        end
        chk("after_reset_pulses", pulses, 1);
        chk("after_reset_pulse_at", first_p, 799);

        // Stall at the wrap point: the count parks at 799 with no further pulse.
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0);
            if (enable_v_counter) pulses++;
        end
        chk("stall_count", int'(h_count), 799);
        chk("stall_pulses", pulses, 0);
        tick(1'b0, 1'b1);
        chk("resume_count", int'(h_count), 0);
        chk("resume_ls", int'(line_start), 1);

        // Stall 3 cycles at 655 and 751: hsync edges shift by the stalls.
        tick(1'b1, 1'b0);
        fall = -1; rise = -1; st1 = 0; st2 = 0; prev_hs = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            en_v = 1'b1;
            if (m_count == 655 && st1 < 3) begin en_v = 1'b0; st1++; end
            else if (m_count == 751 && st2 < 3) begin en_v = 1'b0; st2++; end
            tick(1'b0, en_v);
            if (prev_hs && !hsync && fall < 0) fall = k;
            if (!prev_hs && hsync && rise < 0) rise = k;
            prev_hs = hsync;
        end
        chk("stall_hsync_fall", fall, 656 + 3);
        chk("stall_hsync_rise", rise, 752 + 6);

        // Randomized enable and occasional reset.
        for (int k = 0; k < 3000; k++)
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
